// File: rtl/xgmii_tx_framer.sv
// Serializes one buffered Ethernet frame onto a 64-bit XGMII TX lane set with /S/, /T/ and IPG idles.
// Optional /E/ word injection is compiled in with `define XGMII_ERR_INJECT_EN.
module xgmii_tx_framer #(
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int IPG_BYTES        = 12
) (
  input  logic                                  clk,
  input  logic                                  i_rst,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [(PAYLOAD_MAX_SIZE+26)*8-1:0]    i_frame,
  input  logic [15:0]                           i_frame_bytes,
`ifdef XGMII_ERR_INJECT_EN
  input  logic                                  i_err_inject,
`endif
  output logic [63:0]                           o_txd,
  output logic [7:0]                            o_txc,
  output logic                                  o_busy,
  output logic                                  o_len_err,
  output logic [15:0]                           o_frame_cnt,
  output logic [1:0]                            o_dbg_state
);
  localparam int FRAME_BYTES = PAYLOAD_MAX_SIZE + 26;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;
  localparam int WORDS       = (FRAME_BYTES + 7) / 8;
  localparam int WW          = (WORDS > 2) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TERM, S_IPG} state_e;

  // Handshake: a frame is accepted on any rising edge where i_valid && o_ready;
  // o_ready depends only on internal state, never on i_valid.
  state_e                 state_q, state_d;
  logic [WORDS*64-1:0]    frame_q, frame_d;
  logic [15:0]            n_q, n_d;
  logic [WW-1:0]          w_q, w_d;
  logic [6:0]             ipg_q, ipg_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   len_err_q, len_err_d;
`ifdef XGMII_ERR_INJECT_EN
  logic                   err_q, err_d;
`endif

  logic [2:0]  rem;
  logic        is_last, t_word, accept, len_ok, enters_t;
  logic [6:0]  idles, ipg_now;

  assign rem     = n_q[2:0];
  assign is_last = (state_q == S_DATA) && (16'({w_q, 3'b000}) + 16'd8 >= n_q);
  assign t_word  = (state_q == S_TERM) || (is_last && rem != 3'd0);
  assign len_ok  = (i_frame_bytes >= 16'd9) && (i_frame_bytes <= 16'(FRAME_BYTES));
  assign accept  = i_valid && o_ready;

  // Idle bytes contributed by the word currently on the output.
  always_comb begin
    idles = 7'd0;
    case (state_q)
      S_TERM:  idles = 7'd7;
      S_IPG:   idles = 7'd8;
      S_DATA:  if (t_word) idles = 7'd7 - {4'b0000, rem};
      default: idles = 7'd0;
    endcase
    ipg_now = ((state_q == S_IPG) ? ipg_q : 7'd0) + idles;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      n_q       <= '0;
      w_q       <= '0;
      ipg_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
`ifdef XGMII_ERR_INJECT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      n_q       <= n_d;
      w_q       <= w_d;
      ipg_q     <= ipg_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
`ifdef XGMII_ERR_INJECT_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    n_d       = n_q;
    w_d       = w_q;
    ipg_d     = ipg_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    case (state_q)
      S_DATA: begin
        if (!is_last)             w_d = w_q + 1'b1;
        else if (rem == 3'd0)     state_d = S_TERM;
        else if (!o_ready) begin  state_d = S_IPG; ipg_d = ipg_now; end
        else                      state_d = S_IDLE;
      end
      S_TERM, S_IPG: begin
        if (!o_ready) begin state_d = S_IPG; ipg_d = ipg_now; end
        else                state_d = S_IDLE;
      end
      default: ;
    endcase
    // A rejected frame leaves the framer idle; a good one restarts at word 0.
    if (accept) begin
      if (len_ok) begin
        state_d                  = S_DATA;
        w_d                      = '0;
        n_d                      = i_frame_bytes;
        frame_d                  = '0;
        frame_d[FRAME_BITS-1:0]  = i_frame;
      end else begin
        len_err_d = 1'b1;
      end
    end
    // Count the frame as the /T/-bearing word is loaded onto the output.
    enters_t = (state_d == S_TERM) ||
               ((state_d == S_DATA) && (16'({w_d, 3'b000}) + 16'd8 >= n_d) && (n_d[2:0] != 3'd0));
    if (enters_t) cnt_d = cnt_q + 16'd1;
`ifdef XGMII_ERR_INJECT_EN
    err_d = i_err_inject && (state_d == S_DATA) && (w_d != '0);
`endif
  end

  always_comb begin
    o_txd = 64'h0707070707070707;
    o_txc = 8'hFF;
    case (state_q)
      S_DATA: begin
        o_txd = frame_q[{w_q, 6'd0} +: 64];
        o_txc = 8'h00;
        if (w_q == '0) begin
          o_txd[7:0] = 8'hFB;
          o_txc[0]   = 1'b1;
        end
        if (t_word) begin
          for (int j = 0; j < 8; j++) begin
            if (j == int'(rem)) begin
              o_txd[8*j +: 8] = 8'hFD;
              o_txc[j]        = 1'b1;
            end else if (j > int'(rem)) begin
              o_txd[8*j +: 8] = 8'h07;
              o_txc[j]        = 1'b1;
            end
          end
        end
`ifdef XGMII_ERR_INJECT_EN
        if (err_q && !t_word) begin
          o_txd = {8{8'hFE}};
          o_txc = 8'hFF;
        end
`endif
      end
      S_TERM:  o_txd = 64'h07070707070707FD;
      default: ;
    endcase
    o_ready     = (state_q == S_IDLE) ||
                  ((t_word || state_q == S_IPG) && (ipg_now >= 7'(IPG_BYTES)));
    o_busy      = (state_q != S_IDLE) && !o_ready;
    o_len_err   = len_err_q;
    o_frame_cnt = cnt_q;
    o_dbg_state = state_q;
  end
endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Directed bench for xgmii_tx_framer: expected lanes come from a byte-level wire model of the frame.
module tb_xgmii_tx_framer;
  localparam int PMAX = 1500;
  localparam int IPG  = 12;
  localparam int FB   = PMAX + 26;
  localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};

  logic            clk = 1'b0;
  logic            i_rst, i_valid;
  logic            o_ready, o_busy, o_len_err;
  logic [FB*8-1:0] i_frame;
  logic [15:0]     i_frame_bytes, o_frame_cnt;
  logic [63:0]     o_txd;
  logic [7:0]      o_txc;
  logic [1:0]      o_dbg_state;
`ifdef XGMII_ERR_INJECT_EN
  logic            i_err_inject = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int idle_run;

  xgmii_tx_framer #(.PAYLOAD_MAX_SIZE(PMAX), .IPG_BYTES(IPG)) dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_frame(i_frame), .i_frame_bytes(i_frame_bytes),
`ifdef XGMII_ERR_INJECT_EN
    .i_err_inject(i_err_inject),
`endif
    .o_txd(o_txd), .o_txc(o_txc), .o_busy(o_busy), .o_len_err(o_len_err),
    .o_frame_cnt(o_frame_cnt), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] byte_of(input int k, input int seed);
    return 8'((k * 13 + seed) & 255);
  endfunction

  function automatic logic [FB*8-1:0] mk_frame(input int n, input int seed);
    logic [FB*8-1:0] f = '0;
    for (int k = 0; k < n && k < FB; k++) f[8*k +: 8] = byte_of(k, seed);
    return f;
  endfunction

  // Wire model: {txc, txd} for word w of an n-byte frame, /T/ right after byte n-1.
  function automatic logic [71:0] exp_word(input int n, input int seed, input int w);
    logic [63:0] d = '0;
    logic [7:0]  c = '0;
    for (int j = 0; j < 8; j++) begin
      int idx = 8 * w + j;
      if (w == 0 && j == 0) begin d[8*j +: 8] = 8'hFB; c[j] = 1'b1; end
      else if (idx < n)     begin d[8*j +: 8] = byte_of(idx, seed); c[j] = 1'b0; end
      else if (idx == n)    begin d[8*j +: 8] = 8'hFD; c[j] = 1'b1; end
      else                  begin d[8*j +: 8] = 8'h07; c[j] = 1'b1; end
    end
    return {c, d};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input int seed);
    i_valid       = 1'b1;
    i_frame       = mk_frame(n, seed);
    i_frame_bytes = 16'(n);
  endtask

  // Sends one frame from IDLE and follows it through the IPG until o_ready returns.
  task automatic send_frame(input int n, input int seed);
    int gap;
    @(negedge clk);
    drive(n, seed);
    chk("ready_before_accept", 72'(o_ready), 72'd1);
    @(negedge clk);
    i_valid = 1'b0;
    for (int w = 0; w <= n / 8; w++) begin
      chk($sformatf("n%0d_word%0d", n, w), {o_txc, o_txd}, exp_word(n, seed, w));
      if (w == 0) chk("busy_word0", 72'(o_busy), 72'd1);
      if (w < n / 8) begin
        chk("ready_mid", 72'(o_ready), 72'd0);
        @(negedge clk);
      end
    end
    gap = 7 - (n % 8);
    chk("ready_t_word", 72'(o_ready), 72'(gap >= IPG));
    while (gap < IPG) begin
      @(negedge clk);
      gap += 8;
      chk("ipg_idle_word", {o_txc, o_txd}, IDLE_W);
      chk("ipg_ready", 72'(o_ready), 72'(gap >= IPG));
      chk("ipg_busy", 72'(o_busy), 72'(gap < IPG));
    end
    exp_cnt++;
    chk("frame_cnt", 72'(o_frame_cnt), 72'(exp_cnt));
  endtask

  task automatic len_reject(input int n);
    @(negedge clk);
    drive(n, 5);
    @(negedge clk);
    i_valid = 1'b0;
    chk($sformatf("len_err_pulse_n%0d", n), 72'(o_len_err), 72'd1);
    chk("len_err_idle_out", {o_txc, o_txd}, IDLE_W);
    chk("len_err_ready", 72'(o_ready), 72'd1);
    @(negedge clk);
    chk("len_err_cleared", 72'(o_len_err), 72'd0);
    chk("len_err_still_idle", {o_txc, o_txd}, IDLE_W);
    chk("len_err_cnt", 72'(o_frame_cnt), 72'(exp_cnt));
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_frame = '0; i_frame_bytes = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", {o_txc, o_txd}, IDLE_W);
    chk("reset_ready", 72'(o_ready), 72'd1);
    chk("reset_busy", 72'(o_busy), 72'd0);
    chk("reset_len_err", 72'(o_len_err), 72'd0);
    chk("reset_cnt", 72'(o_frame_cnt), 72'd0);
    chk("reset_state", 72'(o_dbg_state), 72'd0);
    i_rst = 1'b0;

    send_frame(72, 1);   // N%8==0: separate TERM word, ready in cycle 11
    send_frame(77, 2);   // r=5: txc=E0 on last word, ready only in cycle 12
    send_frame(9, 3);    // minimum legal length
    @(negedge clk);
    chk("idle_after_frames", {o_txc, o_txd}, IDLE_W);

    // Back-to-back: i_valid held high, second /S/ lands in cycle 12.
    @(negedge clk);
    drive(72, 7);
    @(negedge clk);
    drive(72, 8);
    idle_run = 0;
    for (int w = 0; w <= 9; w++) begin
      chk("b2b_f1_word", {o_txc, o_txd}, exp_word(72, 7, w));
      if (w == 9) for (int j = 1; j < 8; j++) idle_run += int'(o_txc[j] && o_txd[8*j +: 8] == 8'h07);
      @(negedge clk);
    end
    chk("b2b_gap_word", {o_txc, o_txd}, IDLE_W);
    chk("b2b_gap_ready", 72'(o_ready), 72'd1);
    for (int j = 0; j < 8; j++) idle_run += int'(o_txc[j] && o_txd[8*j +: 8] == 8'h07);
    @(negedge clk);
    i_valid = 1'b0;
    chk("b2b_second_start", {o_txc, o_txd}, exp_word(72, 8, 0));
    chk("b2b_idle_bytes", 72'(idle_run), 72'd15);
    for (int w = 1; w <= 9; w++) begin
      @(negedge clk);
      chk("b2b_f2_word", {o_txc, o_txd}, exp_word(72, 8, w));
    end
    @(negedge clk);
    chk("b2b_end_ready", 72'(o_ready), 72'd1);
    exp_cnt += 2;
    chk("b2b_cnt", 72'(o_frame_cnt), 72'(exp_cnt));

    len_reject(8);
    len_reject(FB + 1);

`ifdef XGMII_ERR_INJECT_EN
    @(negedge clk);
    drive(72, 9);
    @(negedge clk);
    i_valid = 1'b0;
    for (int w = 0; w <= 9; w++) begin
      if (w == 3) chk("err_word3", {o_txc, o_txd}, {8'hFF, {8{8'hFE}}});
      else        chk("err_frame_word", {o_txc, o_txd}, exp_word(72, 9, w));
      i_err_inject = (w == 2);
      @(negedge clk);
    end
    i_err_inject = 1'b0;
    chk("err_ipg_ready", 72'(o_ready), 72'd1);
    exp_cnt++;
    chk("err_cnt", 72'(o_frame_cnt), 72'(exp_cnt));
`endif

    // Reset in cycle 5 of an N=100 frame: idle at once, counter cleared.
    @(negedge clk);
    drive(100, 4);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_word4", {o_txc, o_txd}, exp_word(100, 4, 4));
    #2 i_rst = 1'b1;
    #1;
    chk("rst_mid_out", {o_txc, o_txd}, IDLE_W);
    chk("rst_mid_ready", 72'(o_ready), 72'd1);
    chk("rst_mid_busy", 72'(o_busy), 72'd0);
    chk("rst_mid_cnt", 72'(o_frame_cnt), 72'd0);
    @(negedge clk);
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_after_idle", {o_txc, o_txd}, IDLE_W);
    end
    chk("rst_after_cnt", 72'(o_frame_cnt), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xgmii_tx_framer.md
Name: xgmii_tx_framer

Overview:
- Downstream of the MAC frame generator. Takes one complete Ethernet frame as a flat byte register (preamble, SFD, header, payload, FCS) and serializes it onto a 64-bit XGMII-style TX interface (8 lanes, 8-bit control).
- Inserts /S/, /T/ and idle control characters and enforces a minimum inter-packet gap (IPG).
- Feeds the 64b/66b encoder of the BASE-R transmit path.

Parameters:
- PAYLOAD_MAX_SIZE, 1500: maximum payload bytes. Frame register holds PAYLOAD_MAX_SIZE+26 bytes (8 preamble/SFD + 14 header + 4 FCS).
- IPG_BYTES, 12: minimum idle bytes between a /T/ and the next /S/, range 1..32.

Ports:
- clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  frame available on i_frame/i_frame_bytes
- o_ready  out  1  framer accepts a frame this cycle
- i_frame  in  (PAYLOAD_MAX_SIZE+26)*8  frame bytes; byte k = i_frame[8k +: 8]; byte 0 transmitted first
- i_frame_bytes  in  16  valid byte count, preamble through FCS
- o_txd  out  64  TX data; lane i = o_txd[8i +: 8]; lane 0 first on wire
- o_txc  out  8  TX control; bit i flags lane i as a control character
- o_busy  out  1  high from accept until the IPG completes
- o_len_err  out  1  one-cycle pulse when a frame is rejected for its length
- o_frame_cnt  out  16  frames completed (/T/ emitted); wraps 0xFFFF→0

Behaviour:
- Reset values: o_txd=0x0707070707070707, o_txc=0xFF, o_ready=1, o_busy=0, o_len_err=0, o_frame_cnt=0, state=IDLE. Reset is asynchronous. Asserting reset mid-frame drives idle immediately; no /T/ is sent and the counter is not incremented.
- Accept: i_valid & o_ready at a rising edge. On accept, i_frame and i_frame_bytes are registered. Inputs are don't-care afterwards.
- Length check: N=i_frame_bytes must satisfy 9 ≤ N ≤ PAYLOAD_MAX_SIZE+26. Otherwise:
  - o_len_err pulses in the cycle after accept;
  - no output is produced;
  - state stays IDLE.
- States:
  - IDLE: outputs idle words; o_ready=1.
  - DATA: emits words w=0..floor((N-1)/8), lane j carrying byte 8w+j.
  - TERM: used only when N%8==0; emits a word with FD in lane 0 and 07 in lanes 1-7, o_txc=0xFF.
  - IPG: emits full idle words.
- Latency: first word (w=0) appears on o_txd in the cycle after accept.
- Word 0: lane 0 is replaced with /S/ (0xFB, txc bit 0=1). Lanes 1-7 carry bytes 1-7 as data. o_txc=0x01.
- Middle data words: o_txc=0x00.
- Last data word when N%8=r≠0:
  - lanes 0..r-1 carry data;
  - lane r carries /T/ (0xFD);
  - lanes r+1..7 carry 07;
  - o_txc = ~((1<<r)-1) & 0xFF;
  - next state is IPG (TERM skipped).
- Start position: /S/ is always in lane 0; no deficit-idle or lane-4 start.
- IPG counting:
  - idle bytes following /T/ in its own word are counted;
  - each full idle word adds 8;
  - the framer stays in IPG until count ≥ IPG_BYTES, rounding up to whole words.
- o_ready:
  - high in IDLE;
  - high in the cycle whose output word brings the IPG count to ≥ IPG_BYTES (the T word itself qualifies if its trailing idles suffice);
  - back-to-back accept in that cycle puts /S/ in the next cycle;
  - otherwise the framer returns to IDLE.
- o_busy = !o_ready, excluding IDLE.
- o_frame_cnt increments in the cycle the /T/ word is on the output.
- Frame content (preamble, CRC) is transmitted unmodified; no FCS check or recompute.

Optional Feature:
- XGMII_ERR_INJECT_EN defined:
  - adds input i_err_inject (1 bit);
  - if sampled high while a DATA word (not word 0) is being loaded, that whole word is output as /E/: all lanes 0xFE, o_txc=0xFF;
  - byte position still advances, and /T/ placement is unchanged.
- Undefined: port absent, no /E/ generation.

Test Plan:
- N=72 accepted cycle 0:
  - cycles 1-9: data words, cycle 1 lane0=FB, txc=0x01;
  - cycle 10: FD + 7×07, txc=0xFF;
  - cycle 11: idle word with o_ready=1;
  - o_frame_cnt=1.
- N=77:
  - cycle 10: bytes 72-76 in lanes 0-4, lane5=FD, txc=0xE0;
  - cycles 11-12: idle words;
  - o_ready high only in cycle 12.
- Back-to-back: two N=72 frames with i_valid held high → second FB in cycle 12; exactly 15 idle bytes between them.
- N=8 and N=1527 (PAYLOAD_MAX_SIZE=1500) → o_len_err pulse next cycle, idle output throughout, o_frame_cnt unchanged.
- i_rst asserted at cycle 5 of an N=100 frame → same-cycle idle output, o_ready=1, o_frame_cnt=0, no FD emitted.
- With XGMII_ERR_INJECT_EN, i_err_inject pulsed for word 3 of N=72 → cycle 4 all FE with txc=0xFF; cycle 10 still FD word.
